// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the EX-stage multiply/divide sequencer:
//   - muldiv_state_e : sequencer state encoding (IDLE, RUN, WB)
//   - default latencies for multiply and divide, default counter width
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } muldiv_state_e;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// -----------------------------------------------------------------------------
// muldiv_cycle_counter
// Loadable down-counter that tracks the remaining RUN cycles of the mul/div
// unit. Load has priority over decrement.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load        : load load_val this cycle
//   load_val    : value to load (remaining cycles minus one)
//   dec         : decrement by one this cycle
//   zero        : count is zero
// -----------------------------------------------------------------------------
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_stall_ctrl
// Sequences the multi-cycle multiply/divide unit in EX and merges its stall
// with the load-use stall into one pipeline stall (pc_write/if_id_write low,
// stall_mux high).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   lu_stall       : load-use stall request from the hazard unit
//   id_is_muldiv   : ID holds mult/multu/div/divu
//   id_uses_hilo   : ID holds mfhi/mflo/mthi/mtlo
//   ex_start       : mul/div valid in EX this cycle
//   ex_is_div      : op kind qualifying ex_start (1 = divide)
//   ex_signed      : signedness qualifying ex_start
//   ex_kill        : EX instruction flushed this cycle
//   unit_go        : one-cycle start pulse to the datapath
//   unit_is_div    : latched op kind, valid while busy
//   unit_signed    : latched signedness, valid while busy
//   hilo_write     : one-cycle HI/LO write enable (high exactly in WB)
//   busy           : sequencer not IDLE
//   pc_write       : 0 holds the PC
//   if_id_write    : 0 holds IF/ID
//   stall_mux      : 1 zeroes ID/EX control (bubble)
//   proto_err      : sticky, ex_start seen while not IDLE
//
// Start protocol: ex_start is a one-cycle request with no back-pressure. It is
// accepted only in IDLE and only when ex_kill is low in the same cycle; the
// ID-stage hold guarantees no second request arrives while busy, so one that
// does is dropped and flagged on proto_err.
// -----------------------------------------------------------------------------
module muldiv_stall_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lu_stall,
    input  logic id_is_muldiv,
    input  logic id_uses_hilo,
    input  logic ex_start,
    input  logic ex_is_div,
    input  logic ex_signed,
    input  logic ex_kill,
    output logic unit_go,
    output logic unit_is_div,
    output logic unit_signed,
    output logic hilo_write,
    output logic busy,
    output logic pc_write,
    output logic if_id_write,
    output logic stall_mux,
    output logic proto_err
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    muldiv_state_e state;
    logic          accept;
    logic          cnt_zero;
    logic          cnt_dec;
    logic          id_dep;
    logic          hold;

    assign accept  = (state == IDLE) && ex_start && !ex_kill;
    // Do not decrement on the last RUN cycle so the counter rests at zero.
    assign cnt_dec = (state == RUN) && !cnt_zero;

    muldiv_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (ex_is_div ? DIV_LOAD : MUL_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            unit_go     <= 1'b0;
            unit_is_div <= 1'b0;
            unit_signed <= 1'b0;
            hilo_write  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            unit_go    <= 1'b0;
            hilo_write <= 1'b0;
            if (ex_start && (state != IDLE)) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= RUN;
                        unit_go     <= 1'b1;
                        unit_is_div <= ex_is_div;
                        unit_signed <= ex_signed;
                    end
                end
                RUN: begin
                    if (cnt_zero) begin
                        state      <= WB;
                        hilo_write <= 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The instruction in ID conflicts if it is another mul/div or touches
    // HI/LO. No conflict in WB: HI/LO is written at the WB edge, before the
    // ID instruction reaches EX.
    assign id_dep = id_is_muldiv || id_uses_hilo;
    assign hold   = lu_stall
                 || ((state == RUN) && id_dep)
                 || (accept && id_dep);

    assign busy        = (state != IDLE);
    assign pc_write    = !hold;
    assign if_id_write = !hold;
    assign stall_mux   = hold;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_stall_ctrl
// Directed bench for muldiv_stall_ctrl with default parameters
// (MUL_CYCLES=4, DIV_CYCLES=32). Cycle 0 of each sequence is the cycle in
// which ex_start is presented; the accept edge ends cycle 0.
// -----------------------------------------------------------------------------
module tb_muldiv_stall_ctrl;

    logic clk;
    logic rst_n;
    logic lu_stall;
    logic id_is_muldiv;
    logic id_uses_hilo;
    logic ex_start;
    logic ex_is_div;
    logic ex_signed;
    logic ex_kill;
    logic unit_go;
    logic unit_is_div;
    logic unit_signed;
    logic hilo_write;
    logic busy;
    logic pc_write;
    logic if_id_write;
    logic stall_mux;
    logic proto_err;

    int checks = 0;
    int errors = 0;
    int hilo_seen;

    muldiv_stall_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lu_stall     (lu_stall),
        .id_is_muldiv (id_is_muldiv),
        .id_uses_hilo (id_uses_hilo),
        .ex_start     (ex_start),
        .ex_is_div    (ex_is_div),
        .ex_signed    (ex_signed),
        .ex_kill      (ex_kill),
        .unit_go      (unit_go),
        .unit_is_div  (unit_is_div),
        .unit_signed  (unit_signed),
        .hilo_write   (hilo_write),
        .busy         (busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .stall_mux    (stall_mux),
        .proto_err    (proto_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven there.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow the freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        lu_stall     = 1'b0;
        id_is_muldiv = 1'b0;
        id_uses_hilo = 1'b0;
        ex_start     = 1'b0;
        ex_is_div    = 1'b0;
        ex_signed    = 1'b0;
        ex_kill      = 1'b0;
    endtask

    task automatic check_stall(input string tag, input logic exp_hold);
        check({tag, ".pc_write"},    32'(pc_write),    32'(!exp_hold));
        check({tag, ".if_id_write"}, 32'(if_id_write), 32'(!exp_hold));
        check({tag, ".stall_mux"},   32'(stall_mux),   32'(exp_hold));
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;

        // 1. reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst.unit_go",    32'(unit_go),    32'd0);
        check("rst.hilo_write", 32'(hilo_write), 32'd0);
        check("rst.busy",       32'(busy),       32'd0);
        check("rst.proto_err",  32'(proto_err),  32'd0);
        check_stall("rst", 1'b0);
        rst_n = 1'b1;

        // 2. multiply: go in cycle 1, busy cycles 1..5, hilo_write in cycle 5
        next_cycle();
        ex_start  = 1'b1;
        ex_is_div = 1'b0;
        ex_signed = 1'b1;
        settle();
        check("mul.c0.busy", 32'(busy), 32'd0);
        check_stall("mul.c0", 1'b0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            clear_inputs();
            settle();
            check($sformatf("mul.c%0d.unit_go", c),    32'(unit_go),    32'(c == 1));
            check($sformatf("mul.c%0d.busy", c),       32'(busy),       32'(c >= 1 && c <= 5));
            check($sformatf("mul.c%0d.hilo_write", c), 32'(hilo_write), 32'(c == 5));
            if (c == 1) begin
                check("mul.unit_is_div", 32'(unit_is_div), 32'd0);
                check("mul.unit_signed", 32'(unit_signed), 32'd1);
            end
        end

        // 3. divide with mflo waiting in ID: stalled cycles 0..32, released in WB (33)
        next_cycle();
        ex_start     = 1'b1;
        ex_is_div    = 1'b1;
        ex_signed    = 1'b0;
        id_uses_hilo = 1'b1;
        settle();
        check_stall("div.c0", 1'b1);
        for (int c = 1; c <= 34; c++) begin
            next_cycle();
            clear_inputs();
            id_uses_hilo = (c <= 33);
            settle();
            check_stall($sformatf("div.c%0d", c), (c <= 32));
            check($sformatf("div.c%0d.hilo_write", c), 32'(hilo_write), 32'(c == 33));
            if (c == 1) begin
                check("div.unit_is_div", 32'(unit_is_div), 32'd1);
                check("div.unit_signed", 32'(unit_signed), 32'd0);
            end
        end
        check("div.end.busy", 32'(busy), 32'd0);

        // 4. killed start: no state change, no pulse, no stall
        next_cycle();
        ex_start     = 1'b1;
        ex_kill      = 1'b1;
        id_is_muldiv = 1'b1;
        settle();
        check_stall("kill.c0", 1'b0);
        next_cycle();
        clear_inputs();
        settle();
        check("kill.c1.busy",    32'(busy),    32'd0);
        check("kill.c1.unit_go", 32'(unit_go), 32'd0);

        // 5. load-use stall during RUN with an independent ID instruction
        next_cycle();
        ex_start = 1'b1;
        settle();
        check_stall("lu.c0", 1'b0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            clear_inputs();
            lu_stall = (c == 2 || c == 3);
            settle();
            check_stall($sformatf("lu.c%0d", c), (c == 2 || c == 3));
            check($sformatf("lu.c%0d.hilo_write", c), 32'(hilo_write), 32'(c == 5));
        end
        check("lu.proto_err", 32'(proto_err), 32'd0);

        // 6a. asynchronous reset mid-RUN (count 10 in cycle 22): hilo_write never fires
        next_cycle();
        ex_start  = 1'b1;
        ex_is_div = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            next_cycle();
            clear_inputs();
        end
        settle();
        check("arst.pre.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        settle();
        check("arst.busy",       32'(busy),       32'd0);
        check("arst.hilo_write", 32'(hilo_write), 32'd0);
        #1;
        rst_n = 1'b1;
        hilo_seen = 0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            settle();
            if (hilo_write) hilo_seen++;
        end
        check("arst.hilo_count", 32'(hilo_seen), 32'd0);
        check("arst.idle.busy",  32'(busy),      32'd0);

        // 6b. second ex_start while busy: ignored, proto_err set and sticky
        next_cycle();
        ex_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            clear_inputs();
            ex_start = (c == 2);
            settle();
            if (c == 2) check("perr.c2.proto_err", 32'(proto_err), 32'd0);
            if (c >= 3) check($sformatf("perr.c%0d.proto_err", c), 32'(proto_err), 32'd1);
            check($sformatf("perr.c%0d.busy", c),       32'(busy),       32'(c <= 5));
            check($sformatf("perr.c%0d.hilo_write", c), 32'(hilo_write), 32'(c == 5));
            check($sformatf("perr.c%0d.unit_go", c),    32'(unit_go),    32'(c == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
